memblock_tbus_arb: RTL



---
 rtl/memblock_tbus_arb_pkg.sv | 17 +
 rtl/memblock_tbus_arb_rr_arb2.sv | 21 ++
 rtl/memblock_tbus_arb.sv | 125 ++++++++++++
 3 files changed

// File: rtl/memblock_tbus_arb_pkg.sv
// Shared memblock definitions for the tbus port into the dcache:
// optype codes, owner encoding and the arbiter FSM states.
package memblock_tbus_arb_pkg;

  localparam logic [1:0] TBUS_READ  = 2'd0;
  localparam logic [1:0] TBUS_WRITE = 2'd1;

  localparam logic OWNER_LD = 1'b0;
  localparam logic OWNER_ST = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } tbus_state_e;

endpackage

// File: rtl/memblock_tbus_arb_rr_arb2.sv
// Two-way round-robin pick; bit 0 is the load side, bit 1 the store side.
// On a tie the side opposite last_grant wins.
module rr_arb2
  import memblock_tbus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b11:   gnt = (last_grant == OWNER_ST) ? 2'b01 : 2'b10;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/memblock_tbus_arb.sv
// Arbiter and sequencer for the single tbus port into the dcache,
// shared by the load unit and the store-queue commit path.
module memblock_tbus_arb
  import memblock_tbus_arb_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MASK_W   = 64,
  parameter int OPTYPE_W = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ld_req_valid,
  output logic                ld_req_ready,
  input  logic [DATA_W-1:0]   ld_req_index,
  input  logic [DATA_W-1:0]   ld_req_write_data,
  input  logic [MASK_W-1:0]   ld_req_write_mask,
  input  logic [OPTYPE_W-1:0] ld_req_optype,
  output logic [DATA_W-1:0]   ld_read_data,
  output logic                ld_operation_done,
  input  logic                ld_flush_valid,
  input  logic                st_req_valid,
  output logic                st_req_ready,
  input  logic [DATA_W-1:0]   st_req_index,
  input  logic [DATA_W-1:0]   st_req_write_data,
  input  logic [MASK_W-1:0]   st_req_write_mask,
  input  logic [OPTYPE_W-1:0] st_req_optype,
  output logic                st_operation_done,
  output logic                dc_req_valid,
  input  logic                dc_req_ready,
  output logic [DATA_W-1:0]   dc_req_index,
  output logic [DATA_W-1:0]   dc_req_write_data,
  output logic [MASK_W-1:0]   dc_req_write_mask,
  output logic [OPTYPE_W-1:0] dc_req_optype,
  input  logic [DATA_W-1:0]   dc_read_data,
  input  logic                dc_operation_done,
  output logic                busy
);

  tbus_state_e state_q, state_d;

  logic                owner_q;
  logic                last_grant_q;
  logic                squash_q;
  logic [DATA_W-1:0]   index_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   mask_q;
  logic [OPTYPE_W-1:0] optype_q;

  logic [1:0] gnt;
  logic       grant;
  logic       ld_kill;
  logic       fwd;

  // A load that is being flushed this cycle must not win the port.
  rr_arb2 u_arb (
    .req        ({st_req_valid, ld_req_valid & ~ld_flush_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign ld_req_ready = (state_q == IDLE) & gnt[0];
  assign st_req_ready = (state_q == IDLE) & gnt[1];
  assign grant        = ld_req_ready | st_req_ready;

  assign ld_kill = (owner_q == OWNER_LD) & ld_flush_valid;
  assign fwd     = (state_q == WAIT) & dc_operation_done
                 & ~squash_q & ~ld_kill;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (grant) state_d = REQ;
      REQ: begin
        if (ld_kill)           state_d = IDLE;
        else if (dc_req_ready) state_d = WAIT;
      end
      WAIT: if (dc_operation_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q      <= OWNER_LD;
      last_grant_q <= OWNER_ST;
      squash_q     <= 1'b0;
      index_q      <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      optype_q     <= '0;
    end else begin
      if (grant) begin
        owner_q      <= gnt[1] ? OWNER_ST : OWNER_LD;
        last_grant_q <= gnt[1] ? OWNER_ST : OWNER_LD;
        index_q      <= gnt[1] ? st_req_index      : ld_req_index;
        wdata_q      <= gnt[1] ? st_req_write_data : ld_req_write_data;
        mask_q       <= gnt[1] ? st_req_write_mask : ld_req_write_mask;
        optype_q     <= gnt[1] ? st_req_optype     : ld_req_optype;
      end
      // squash lives only for the WAIT it was set in
      if (state_q == WAIT) begin
        if (dc_operation_done) squash_q <= 1'b0;
        else if (ld_kill)      squash_q <= 1'b1;
      end
    end
  end

  assign dc_req_valid      = (state_q == REQ);
  assign dc_req_index      = index_q;
  assign dc_req_write_data = wdata_q;
  assign dc_req_write_mask = mask_q;
  assign dc_req_optype     = optype_q;

  assign ld_read_data      = dc_read_data;
  assign ld_operation_done = fwd & (owner_q == OWNER_LD);
  assign st_operation_done = fwd & (owner_q == OWNER_ST);

  assign busy = (state_q != IDLE);

endmodule
